// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath word definitions for the CPU building blocks
//
// Purpose: one place for the machine word width and word type used by the
//          selector blocks.
// Contents: WORD_W (word width in bits), word_t (one machine word).
package cpu_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

endpackage : cpu_pkg

// File: rtl/mux_2way_16.sv
// rtl/mux_2way_16.sv - 2-input word selector, the leaf cell of the 8-way tree
//
// Purpose: out = sel ? b : a, purely combinational.
// Ports:
//   a, b  in  WIDTH  data inputs (sel = 0 / sel = 1)
//   sel   in  1      select
//   out   out WIDTH  selected word
module mux_2way_16
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? b : a;

endmodule : mux_2way_16

// File: rtl/mux_8way_16.sv
// rtl/mux_8way_16.sv - 8-input word selector with combinational and registered outputs
//
// Purpose: routes one of eight words to out under a 3-bit select, and keeps a
//          one-cycle registered copy in out_q for pipelined consumers.
// Ports:
//   out    out WIDTH  combinational selected word (a..h for sel 0..7)
//   a..h   in  WIDTH  data inputs
//   sel    in  SEL_W  select
//   clk    in  1      rising-edge clock, only used by out_q
//   reset  in  1      synchronous active-high, clears out_q only
//   out_q  out WIDTH  out registered on the rising clock edge
module mux_8way_16
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int SEL_W = 3
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic [SEL_W-1:0] sel,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] out_q
);

    // Tree levels: sel[0] picks within each pair, sel[1] between pairs,
    // sel[2] between halves. This ordering yields index 0..7 -> a..h.
    logic [WIDTH-1:0] lvl0_ab, lvl0_cd, lvl0_ef, lvl0_gh;
    logic [WIDTH-1:0] lvl1_lo, lvl1_hi;

    mux_2way_16 #(.WIDTH(WIDTH)) u_l0_ab (.a(a), .b(b), .sel(sel[0]), .out(lvl0_ab));
    mux_2way_16 #(.WIDTH(WIDTH)) u_l0_cd (.a(c), .b(d), .sel(sel[0]), .out(lvl0_cd));
    mux_2way_16 #(.WIDTH(WIDTH)) u_l0_ef (.a(e), .b(f), .sel(sel[0]), .out(lvl0_ef));
    mux_2way_16 #(.WIDTH(WIDTH)) u_l0_gh (.a(g), .b(h), .sel(sel[0]), .out(lvl0_gh));

    mux_2way_16 #(.WIDTH(WIDTH)) u_l1_lo (.a(lvl0_ab), .b(lvl0_cd), .sel(sel[1]), .out(lvl1_lo));
    mux_2way_16 #(.WIDTH(WIDTH)) u_l1_hi (.a(lvl0_ef), .b(lvl0_gh), .sel(sel[1]), .out(lvl1_hi));

    mux_2way_16 #(.WIDTH(WIDTH)) u_l2    (.a(lvl1_lo), .b(lvl1_hi), .sel(sel[2]), .out(out));

    // Reset clears only the registered copy; the combinational path ignores it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= out;
        end
    end

endmodule : mux_8way_16

// File: tb/tb_mux_8way_16.sv
// tb/tb_mux_8way_16.sv - self-checking bench for mux_8way_16
module tb_mux_8way_16;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic [2:0]  sel;
    word_t       din [8];
    word_t       out;
    word_t       out_q;

    int n_checks = 0;
    int n_errors = 0;

    word_t exp_out_q_fifo [$];
    word_t exp_reg_q      [$];
    word_t last_reg_exp;

    mux_8way_16 dut (
        .out   (out),
        .a     (din[0]),
        .b     (din[1]),
        .c     (din[2]),
        .d     (din[3]),
        .e     (din[4]),
        .f     (din[5]),
        .g     (din[6]),
        .h     (din[7]),
        .sel   (sel),
        .clk   (clk),
        .reset (reset),
        .out_q (out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic word_t golden(input logic [2:0] s, input word_t w0, input word_t w1,
                                     input word_t w2, input word_t w3, input word_t w4,
                                     input word_t w5, input word_t w6, input word_t w7);
        case (s)
            3'd0:    golden = w0;
            3'd1:    golden = w1;
            3'd2:    golden = w2;
            3'd3:    golden = w3;
            3'd4:    golden = w4;
            3'd5:    golden = w5;
            3'd6:    golden = w6;
            default: golden = w7;
        endcase
    endfunction

    function automatic word_t model_now();
        return golden(sel, din[0], din[1], din[2], din[3], din[4], din[5], din[6], din[7]);
    endfunction

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Push the expected combinational result, let it settle, compare.
    task automatic apply(input string tag);
        exp_out_q_fifo.push_back(model_now());
        #1;
        check(tag, out, exp_out_q_fifo.pop_front());
    endtask

    // Registered-path scoreboard: expectation formed from the inputs seen at the edge.
    always @(posedge clk) begin
        word_t e;
        e = reset ? 16'h0000 : model_now();
        exp_reg_q.push_back(e);
        last_reg_exp = e;
        #1;
        if (exp_reg_q.size() > 0) check("out_q", out_q, exp_reg_q.pop_front());
    end

    initial begin
        reset = 1'b1;
        sel   = 3'd0;
        for (int i = 0; i < 8; i++) din[i] = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // One-hot sweep
        for (int i = 0; i < 8; i++) din[i] = word_t'(16'h0001 << i);
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            sel = 3'(s);
            apply("onehot");
        end

        // Bit independence on f
        @(negedge clk);
        for (int i = 0; i < 8; i++) din[i] = 16'h0000;
        din[5] = 16'hFFFF;
        sel = 3'd5;
        apply("f_all_ones");
        @(negedge clk);
        sel = 3'd4;
        apply("e_zero");

        // Combinational follow without a clock edge
        @(negedge clk);
        sel = 3'd3;
        din[3] = 16'h1234;
        apply("d_1234");
        #1;
        din[3] = 16'hBEEF;
        apply("d_beef");
        check("hold_q", out_q, last_reg_exp);

        // Reset held two cycles while selecting h
        @(negedge clk);
        reset = 1'b1;
        sel = 3'd7;
        din[7] = 16'hA5A5;
        apply("rst_out");
        @(negedge clk);
        @(negedge clk);
        check("rst_q", out_q, 16'h0000);
        reset = 1'b0;
        @(posedge clk);
        #2;
        check("rel_q", out_q, 16'hA5A5);

        // Random vectors
        for (int v = 0; v < 100; v++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) din[i] = word_t'($urandom_range(0, 16'hFFFF));
            sel = 3'($urandom_range(0, 7));
            apply("rand");
        end

        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mux_8way_16
